// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
//
// Classifies the debounced key event stream into gestures: single click,
// double click and long press. Each gesture produces a one-cycle pulse. It sits
// between the key debounce filter and the uart_scope control logic.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   key_flag    one-cycle event strobe from the debounce filter
//   key_state   debounced key level, valid with key_flag (0 = pressed)
//   click       one-cycle pulse: single click recognised
//   dbl_click   one-cycle pulse: double click recognised
//   long_press  one-cycle pulse: long-press threshold reached while held
//   key_held    level: key currently considered held by the decoder
//
// Parameters:
//   CNT_W       counter width, must hold max(LONG_MAX, DBL_MAX)
//   LONG_MAX    last count value of the long-press hold window
//   DBL_MAX     last count value of the double-click gap window
// -----------------------------------------------------------------------------
module key_event_decoder #(
    parameter int               CNT_W    = 27,
    parameter logic [CNT_W-1:0] LONG_MAX = 27'd99_999_999,
    parameter logic [CNT_W-1:0] DBL_MAX  = 27'd14_999_999
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    output logic click,
    output logic dbl_click,
    output logic long_press,
    output logic key_held
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_WAIT2  = 3'd2,
        S_PRESS2 = 3'd3,
        S_LONG   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic click_reg,      click_next;
    logic dbl_click_reg,  dbl_click_next;
    logic long_press_reg, long_press_next;
    logic key_held_reg,   key_held_next;

    logic press_ev;
    logic rel_ev;
    logic long_hit;
    logic dbl_hit;

    assign press_ev = key_flag & ~key_state;
    assign rel_ev   = key_flag &  key_state;

    // Window-end comparisons; the counter never passes these values because
    // the state is always left on the cycle the comparison is true (unless an
    // event wins and leaves the state anyway).
    assign long_hit = (cnt_reg == LONG_MAX);
    assign dbl_hit  = (cnt_reg == DBL_MAX);

    // -------------------------------------------------------------------------
    // State register (also holds the counter and the registered outputs)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= CNT_ZERO;
            click_reg      <= 1'b0;
            dbl_click_reg  <= 1'b0;
            long_press_reg <= 1'b0;
            key_held_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            click_reg      <= click_next;
            dbl_click_reg  <= dbl_click_next;
            long_press_reg <= long_press_next;
            key_held_reg   <= key_held_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = S_IDLE;
        case (state_reg)
            S_IDLE: begin
                state_next = press_ev ? S_PRESS1 : S_IDLE;
            end
            S_PRESS1: begin
                // Release has priority over the long-press threshold.
                if (rel_ev) begin
                    state_next = S_WAIT2;
                end else if (long_hit) begin
                    state_next = S_LONG;
                end else begin
                    state_next = S_PRESS1;
                end
            end
            S_WAIT2: begin
                // A second press has priority over the gap timeout.
                if (press_ev) begin
                    state_next = S_PRESS2;
                end else if (dbl_hit) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_WAIT2;
                end
            end
            S_PRESS2: begin
                state_next = rel_ev ? S_IDLE : S_PRESS2;
            end
            S_LONG: begin
                state_next = rel_ev ? S_IDLE : S_LONG;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Counter restarts at zero on every state change and only runs in the
        // two timed states.
        cnt_next = CNT_ZERO;
        if ((state_next == state_reg) &&
            ((state_reg == S_PRESS1) || (state_reg == S_WAIT2))) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: values loaded into the output registers on the next edge.
    // The pulse conditions are disjoint by state, so at most one is high.
    // -------------------------------------------------------------------------
    always_comb begin
        click_next      = 1'b0;
        dbl_click_next  = 1'b0;
        long_press_next = 1'b0;
        key_held_next   = 1'b0;
        case (state_reg)
            S_PRESS1: long_press_next = ~rel_ev & long_hit;
            S_WAIT2:  click_next      = ~press_ev & dbl_hit;
            S_PRESS2: dbl_click_next  = rel_ev;
            default:  ;
        endcase
        key_held_next = (state_next == S_PRESS1) ||
                        (state_next == S_PRESS2) ||
                        (state_next == S_LONG);
    end

    assign click      = click_reg;
    assign dbl_click  = dbl_click_reg;
    assign long_press = long_press_reg;
    assign key_held   = key_held_reg;

endmodule
